// File: rtl/alu_pipe_ext.sv
// Registered ALU with merged immediate extension, signed overflow, unsigned compare
// and an iterative shift-add multiplier behind valid/ready handshakes.
module alu_pipe_ext #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMM_W-1:0] imm,
  input  logic             use_imm,
  input  logic             ext_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
  } rsp_t;

  state_t           state, state_nxt;
  rsp_t             rsp_q, alu_rsp;
  logic [WIDTH-1:0] imm_ext, b_eff, sum, diff;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             accept, mul_last;

  assign imm_ext  = ext_zero ? WIDTH'(imm) : WIDTH'($signed(imm));
  assign b_eff    = use_imm ? imm_ext : b;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy     = (state == MUL);
  assign result   = rsp_q.result;
  assign zero     = rsp_q.zero;
  assign overflow = rsp_q.overflow;

  assign sum  = a + b_eff;
  assign diff = a - b_eff;

  always_comb begin
    alu_rsp = '0;
    case (op)
      4'd0: alu_rsp.result = a & b_eff;
      4'd1: alu_rsp.result = a | b_eff;
      4'd2: begin
        alu_rsp.result   = sum;
        alu_rsp.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: begin
        alu_rsp.result   = diff;
        alu_rsp.overflow = (a[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd4: alu_rsp.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b_eff))};
      4'd5: alu_rsp.result = {{(WIDTH-1){1'b0}}, (a < b_eff)};
      4'd6: alu_rsp.result = a ^ b_eff;
      4'd7: alu_rsp.result = ~(a | b_eff);
      default: alu_rsp.result = '0;
    endcase
    alu_rsp.zero = (alu_rsp.result == '0);
  end

  // One shift-add step per edge; the last step writes the result directly.
  assign acc_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (op == OP_MUL) ? MUL : DONE;
      MUL:  if (mul_last) state_nxt = DONE;
      DONE: if (out_ready) begin
        if (in_valid) state_nxt = (op == OP_MUL) ? MUL : DONE;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand  <= a;
        mplier <= b_eff;
        acc    <= '0;
        cnt    <= CNT_W'(WIDTH);
      end else begin
        rsp_q <= alu_rsp;
      end
    end else if (state == MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (mul_last) begin
        rsp_q.result   <= acc_sum;
        rsp_q.zero     <= (acc_sum == '0);
        rsp_q.overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_ext.sv
// Scoreboard bench for alu_pipe_ext: expectations queued at issue, compared at handoff.
module tb_alu_pipe_ext;
  localparam int W  = 32;
  localparam int IW = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         o;
  } exp_t;

  logic          clk, rst_n, in_valid, in_ready, use_imm, ext_zero;
  logic [3:0]    op;
  logic [W-1:0]  a, b, result;
  logic [IW-1:0] imm;
  logic          out_valid, out_ready, zero, overflow, busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_pipe_ext #(.WIDTH(W), .IMM_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .imm(imm), .use_imm(use_imm), .ext_zero(ext_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every handoff pops one expectation.
  always @(posedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result=%h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.r || zero !== e.z || overflow !== e.o) begin
          errors++;
          $display("FAIL sb_result: got r=%h z=%b o=%b, expected r=%h z=%b o=%b",
                   result, zero, overflow, e.r, e.z, e.o);
        end
      end
    end
  end

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t     e;
    logic [W:0] s;
    e = '0;
    case (o)
      4'd0: e.r = x & y;
      4'd1: e.r = x | y;
      4'd2: begin s = {x[W-1], x} + {y[W-1], y}; e.r = s[W-1:0]; e.o = s[W] ^ s[W-1]; end
      4'd3: begin s = {x[W-1], x} - {y[W-1], y}; e.r = s[W-1:0]; e.o = s[W] ^ s[W-1]; end
      4'd4: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd5: e.r = (x < y) ? 1 : 0;
      4'd6: e.r = x ^ y;
      4'd7: e.r = ~(x | y);
      4'd8: e.r = x * y;
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic o);
    exp_t e;
    e.r = r; e.z = z; e.o = o;
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [IW-1:0] im, input logic ui, input logic ez,
                       input bit push, input exp_t e);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; imm = im; use_imm = ui; ext_zero = ez; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    imm = '0; use_imm = 1'b0; ext_zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== '0 || zero !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: r=%h z=%b o=%b ov=%b busy=%b ir=%b, expected 0 0 0 0 0 1",
               result, zero, overflow, out_valid, busy, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_extension();
    out_ready = 1'b0;
    issue(4'd2, 32'd5, 32'd0, 16'hFFFF, 1'b1, 1'b0, 1'b1, mk(32'h4, 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ext_sign_latency1: ov=%b r=%h o=%b, expected 1 00000004 0",
               out_valid, result, overflow);
    end
    drain();
    issue(4'd2, 32'd5, 32'd0, 16'hFFFF, 1'b1, 1'b1, 1'b1, mk(32'h00010004, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    issue(4'd3, 32'h80000000, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h7FFFFFFF, 1'b0, 1'b1));
    issue(4'd2, 32'h7FFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h80000000, 1'b0, 1'b1));
    issue(4'd0, 32'h7FFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h1, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_compare();
    out_ready = 1'b1;
    issue(4'd4, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h1, 1'b0, 1'b0));
    issue(4'd5, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b0));
    issue(4'd3, 32'h1234, 32'h1234, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b0));
    drain();
  endtask

  task automatic test_mul();
    int bad;
    out_ready = 1'b0;
    issue(4'd8, 32'd7, 32'd6, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'd42, 1'b0, 1'b0));
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy_window: %0d bad cycles, expected 0", bad);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 32'd42) begin
      errors++;
      $display("FAIL mul_latency: ov=%b busy=%b r=%h, expected 1 0 0000002a", out_valid, busy, result);
    end
    drain();
    issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h1, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_back_to_back();
    int bad;
    out_ready = 1'b0;
    issue(4'd2, 32'd3, 32'd4, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'd7, 1'b0, 1'b0));
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d bad cycles, expected 0", bad);
    end
    @(negedge clk);
    out_ready = 1'b1;
    op = 4'd1; a = 32'hF0; b = 32'h0F; use_imm = 1'b0; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_ready: in_ready=%b, expected 1", in_ready);
    end
    sb.push_back(mk(32'hFF, 1'b0, 1'b0));
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFF) begin
      errors++;
      $display("FAIL stream_no_bubble: ov=%b r=%h, expected 1 000000ff", out_valid, result);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b0;
    issue(4'd8, 32'd7, 32'd6, 16'h0, 1'b0, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== '0 || zero !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul: r=%h z=%b o=%b ov=%b busy=%b ir=%b, expected 0 0 0 0 0 1",
               result, zero, overflow, out_valid, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'd2, 32'd1, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'd2, 1'b0, 1'b0));
    drain();
  endtask

  task automatic test_illegal_op();
    out_ready = 1'b0;
    issue(4'hF, 32'hDEADBEEF, 32'h12345678, 16'h0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: ov=%b r=%h z=%b, expected 1 00000000 1", out_valid, result, zero);
    end
    drain();
  endtask

  task automatic test_random_stream();
    logic [3:0]    o;
    logic [W-1:0]  x, y, be;
    logic [IW-1:0] im;
    logic          ui, ez;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      o  = 4'($urandom_range(0, 9));
      if (o == 4'd9) o = 4'hF;
      x  = $urandom;
      y  = $urandom;
      im = 16'($urandom);
      ui = 1'($urandom_range(0, 1));
      ez = 1'($urandom_range(0, 1));
      if (!ui)     be = y;
      else if (ez) be = {16'h0, im};
      else         be = {{16{im[IW-1]}}, im};
      issue(o, x, y, im, ui, ez, 1'b1, model(o, x, be));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_extension();
    test_overflow();
    test_compare();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_illegal_op();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
